// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a pixel-enable strobe from a clock divider drives
// horizontal/vertical counters, and the sync, enable, coordinate and strobe outputs are registered from them.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int   H_VISIBLE = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter int   CLK_DIV   = 2,
   parameter logic HS_POL    = 1'b0,
   parameter logic VS_POL    = 1'b0,
   parameter int   CNT_W     = 11
) (
   input  logic             CLK_50M,
   input  logic             FPGA_RST,
   input  logic             Enable,
   output logic             Pix_En,
   output logic [CNT_W-1:0] HS_Count,
   output logic [CNT_W-1:0] VS_Count,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             Data_valid,
   output logic [CNT_W-1:0] Pixel_X,
   output logic [CNT_W-1:0] Pixel_Y,
   output logic             Line_Start,
   output logic             Frame_Start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_VIS_BEG = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] V_VIS_BEG = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);

   logic [DIV_W-1:0] div_cnt;
   logic             pix_tick;
   logic             h_sync_act;
   logic             v_sync_act;
   logic             h_vis;
   logic             v_vis;
   logic             vis;

   assign pix_tick   = Enable & (div_cnt == DIV_LAST);
   // Gated with reset so the strobe reads 0 while reset is held, even for CLK_DIV=1.
   assign Pix_En     = pix_tick & ~FPGA_RST;

   assign h_sync_act = (HS_Count < H_SYNC_E);
   assign v_sync_act = (VS_Count < V_SYNC_E);
   assign h_vis      = (HS_Count >= H_VIS_BEG) && (HS_Count < H_VIS_END);
   assign v_vis      = (VS_Count >= V_VIS_BEG) && (VS_Count < V_VIS_END);
   assign vis        = h_vis & v_vis;

   always_ff @(posedge CLK_50M or posedge FPGA_RST) begin
      if (FPGA_RST) begin
         div_cnt <= '0;
      end else if (!Enable || (div_cnt == DIV_LAST)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK_50M or posedge FPGA_RST) begin
      if (FPGA_RST) begin
         HS_Count <= '0;
         VS_Count <= '0;
      end else if (!Enable) begin
         HS_Count <= '0;
         VS_Count <= '0;
      end else if (pix_tick) begin
         if (HS_Count == H_LAST) begin
            HS_Count <= '0;
            VS_Count <= (VS_Count == V_LAST) ? '0 : VS_Count + 1'b1;
         end else begin
            HS_Count <= HS_Count + 1'b1;
         end
      end
   end

   // Decoded from the pre-increment counts, so these trail the raw counters by one pixel.
   always_ff @(posedge CLK_50M or posedge FPGA_RST) begin
      if (FPGA_RST) begin
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         Data_valid  <= 1'b0;
         Pixel_X     <= '0;
         Pixel_Y     <= '0;
         Line_Start  <= 1'b0;
         Frame_Start <= 1'b0;
      end else if (!Enable) begin
         VGA_HS      <= ~HS_POL;
         VGA_VS      <= ~VS_POL;
         Data_valid  <= 1'b0;
         Pixel_X     <= '0;
         Pixel_Y     <= '0;
         Line_Start  <= 1'b0;
         Frame_Start <= 1'b0;
      end else if (pix_tick) begin
         VGA_HS      <= h_sync_act ? HS_POL : ~HS_POL;
         VGA_VS      <= v_sync_act ? VS_POL : ~VS_POL;
         Data_valid  <= vis;
         Pixel_X     <= vis ? (HS_Count - H_VIS_BEG) : '0;
         Pixel_Y     <= vis ? (VS_Count - V_VIS_BEG) : '0;
         Line_Start  <= (HS_Count == '0);
         Frame_Start <= (HS_Count == '0) && (VS_Count == '0);
      end else begin
         Line_Start  <= 1'b0;
         Frame_Start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, tiny, divide-by-3 and mid-size
// geometries exercised in turn on one shared clock.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic rst, m_rst;
   logic d_en, s_en, t_en, m_en;

   logic        d_pe, d_hs, d_vs, d_dv, d_ls, d_fs;
   logic [10:0] d_hc, d_vc, d_px, d_py;
   logic        s_pe, s_hs, s_vs, s_dv, s_ls, s_fs;
   logic [3:0]  s_hc, s_vc, s_px, s_py;
   logic        t_pe, t_hs, t_vs, t_dv, t_ls, t_fs;
   logic [10:0] t_hc, t_vc, t_px, t_py;
   logic        m_pe, m_hs, m_vs, m_dv, m_ls, m_fs;
   logic [7:0]  m_hc, m_vc, m_px, m_py;

   vga_timing_gen u_d (
      .CLK_50M(clk_sys), .FPGA_RST(rst), .Enable(d_en), .Pix_En(d_pe),
      .HS_Count(d_hc), .VS_Count(d_vc), .VGA_HS(d_hs), .VGA_VS(d_vs),
      .Data_valid(d_dv), .Pixel_X(d_px), .Pixel_Y(d_py),
      .Line_Start(d_ls), .Frame_Start(d_fs));

   vga_timing_gen #(
      .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
   ) u_s (
      .CLK_50M(clk_sys), .FPGA_RST(rst), .Enable(s_en), .Pix_En(s_pe),
      .HS_Count(s_hc), .VS_Count(s_vc), .VGA_HS(s_hs), .VGA_VS(s_vs),
      .Data_valid(s_dv), .Pixel_X(s_px), .Pixel_Y(s_py),
      .Line_Start(s_ls), .Frame_Start(s_fs));

   vga_timing_gen #(.CLK_DIV(3)) u_t (
      .CLK_50M(clk_sys), .FPGA_RST(rst), .Enable(t_en), .Pix_En(t_pe),
      .HS_Count(t_hc), .VS_Count(t_vc), .VGA_HS(t_hs), .VGA_VS(t_vs),
      .Data_valid(t_dv), .Pixel_X(t_px), .Pixel_Y(t_py),
      .Line_Start(t_ls), .Frame_Start(t_fs));

   // H: sync 8, back 4, visible 40, front 4 (56); V: sync 2, back 3, visible 30, front 2 (37)
   vga_timing_gen #(
      .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
      .V_VISIBLE(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .CLK_DIV(2), .CNT_W(8)
   ) u_m (
      .CLK_50M(clk_sys), .FPGA_RST(m_rst), .Enable(m_en), .Pix_En(m_pe),
      .HS_Count(m_hc), .VS_Count(m_vc), .VGA_HS(m_hs), .VGA_VS(m_vs),
      .Data_valid(m_dv), .Pixel_X(m_px), .Pixel_Y(m_py),
      .Line_Start(m_ls), .Frame_Start(m_fs));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   int          ls_t[4];
   int          n_ls, n_fs, fs_t, hs_low, vs_low, dv_cnt, pxy_nz, alt_bad, n_pe, last_pe;
   int          gap_bad, hold_bad, per, px_max, py_max, px_bad, cnt, found;
   int          mh, mv, e_hs, e_vs, e_dv, e_px, e_py, e_ls, e_fs;
   logic        prev_pe;
   logic [46:0] prev_v, cur_v;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; m_rst = 1'b1;
      d_en = 1'b0; s_en = 1'b0; t_en = 1'b0; m_en = 1'b0;
      #3;
      chk("rst_d_pe", int'(d_pe), 0);
      chk("rst_d_hc", int'(d_hc), 0);
      chk("rst_d_vc", int'(d_vc), 0);
      chk("rst_d_hs", int'(d_hs), 1);
      chk("rst_d_vs", int'(d_vs), 1);
      chk("rst_d_dv", int'(d_dv), 0);
      chk("rst_d_px", int'(d_px), 0);
      chk("rst_d_py", int'(d_py), 0);
      chk("rst_d_ls", int'(d_ls), 0);
      chk("rst_d_fs", int'(d_fs), 0);
      chk("rst_s_hs", int'(s_hs), 0);
      chk("rst_s_vs", int'(s_vs), 0);
      @(negedge clk_sys);
      rst = 1'b0; m_rst = 1'b0;
      repeat (2) @(posedge clk_sys);

      // default geometry, a few lines from enable
      @(posedge clk_sys); #1;
      d_en = 1'b1;
      n_ls = 0; n_fs = 0; fs_t = -1; hs_low = 0; vs_low = 0; dv_cnt = 0; pxy_nz = 0; alt_bad = 0;
      prev_pe = d_pe;
      for (int cyc = 1; cyc <= 6600; cyc++) begin
         @(posedge clk_sys); #1;
         if (d_pe == prev_pe) alt_bad++;
         prev_pe = d_pe;
         if (d_ls) begin
            if (n_ls < 4) ls_t[n_ls] = cyc;
            n_ls++;
         end
         if (d_fs) begin n_fs++; fs_t = cyc; end
         if (n_ls == 1 && !d_hs) hs_low++;
         if (!d_vs) vs_low++;
         if (d_dv) dv_cnt++;
         if (d_px != 0 || d_py != 0) pxy_nz++;
      end
      chk("d_pe_alternate", alt_bad, 0);
      chk("d_ls_count", n_ls, 5);
      chk("d_ls_period1", ls_t[1] - ls_t[0], 1600);
      chk("d_ls_period2", ls_t[2] - ls_t[1], 1600);
      chk("d_fs_count", n_fs, 1);
      chk("d_fs_first", fs_t, 2);
      chk("d_fs_with_ls", fs_t, ls_t[0]);
      chk("d_hs_low_clks", hs_low, 192);
      chk("d_vs_low_clks", vs_low, 3200);
      chk("d_dv_sync_lines", dv_cnt, 0);
      chk("d_pxy_invisible", pxy_nz, 0);
      d_en = 1'b0;

      // tiny geometry against a one-pixel-behind reference, 3 frames
      @(posedge clk_sys); #1;
      s_en = 1'b1;
      mh = 0; mv = 0; n_fs = 0;
      for (int k = 0; k < 144; k++) begin
         @(posedge clk_sys);
         e_hs = (mh < 2) ? 1 : 0;
         e_vs = (mv < 1) ? 1 : 0;
         e_dv = (mh >= 3 && mh < 7 && mv >= 2 && mv < 5) ? 1 : 0;
         e_px = e_dv ? mh - 3 : 0;
         e_py = e_dv ? mv - 2 : 0;
         e_ls = (mh == 0) ? 1 : 0;
         e_fs = (mh == 0 && mv == 0) ? 1 : 0;
         if (mh == 7) begin
            mh = 0;
            mv = (mv == 5) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
         #1;
         chk("s_pe", int'(s_pe), 1);
         chk("s_hc", int'(s_hc), mh);
         chk("s_vc", int'(s_vc), mv);
         chk("s_hs", int'(s_hs), e_hs);
         chk("s_vs", int'(s_vs), e_vs);
         chk("s_dv", int'(s_dv), e_dv);
         chk("s_px", int'(s_px), e_px);
         chk("s_py", int'(s_py), e_py);
         chk("s_ls", int'(s_ls), e_ls);
         chk("s_fs", int'(s_fs), e_fs);
         if (s_fs) n_fs++;
      end
      chk("s_fs_count", n_fs, 3);
      s_en = 1'b0;
      @(posedge clk_sys); #1;
      chk("s_idle_hs", int'(s_hs), 0);
      chk("s_idle_vs", int'(s_vs), 0);
      chk("s_idle_dv", int'(s_dv), 0);
      chk("s_idle_hc", int'(s_hc), 0);

      // CLK_DIV=3: strobe spacing and hold between strobes
      @(posedge clk_sys); #1;
      t_en = 1'b1;
      prev_pe = t_pe;
      prev_v = {t_hs, t_vs, t_dv, t_px, t_py, t_hc, t_vc};
      n_pe = 0; last_pe = -1; gap_bad = 0; hold_bad = 0; n_ls = 0;
      for (int cyc = 1; cyc <= 2700; cyc++) begin
         @(posedge clk_sys); #1;
         cur_v = {t_hs, t_vs, t_dv, t_px, t_py, t_hc, t_vc};
         if (!prev_pe && cur_v != prev_v) hold_bad++;
         if (t_pe) begin
            if (last_pe >= 0 && cyc - last_pe != 3) gap_bad++;
            last_pe = cyc;
            n_pe++;
         end
         if (t_ls) begin
            if (n_ls < 4) ls_t[n_ls] = cyc;
            n_ls++;
         end
         prev_v = cur_v;
         prev_pe = t_pe;
      end
      chk("t_pe_count", n_pe, 900);
      chk("t_pe_gap", gap_bad, 0);
      chk("t_hold", hold_bad, 0);
      chk("t_ls_count", n_ls, 2);
      chk("t_ls_period", ls_t[1] - ls_t[0], 2400);
      t_en = 1'b0;

      // mid-size geometry: full-frame accounting
      @(posedge clk_sys); #1;
      m_en = 1'b1;
      cnt = 0;
      while (!m_fs && cnt < 100) begin @(posedge clk_sys); #1; cnt++; end
      chk("m_fs_first_seen", int'(m_fs), 1);
      per = 0; dv_cnt = 0; vs_low = 0; n_ls = 0; px_max = 0; py_max = 0; px_bad = 0;
      do begin
         if (m_dv) dv_cnt++;
         if (!m_vs) vs_low++;
         if (m_ls) n_ls++;
         if (int'(m_px) > px_max) px_max = int'(m_px);
         if (int'(m_py) > py_max) py_max = int'(m_py);
         if (!m_dv && (m_px != 0 || m_py != 0)) px_bad++;
         per++;
         @(posedge clk_sys); #1;
      end while (!m_fs && per < 5000);
      chk("m_frame_period", per, 4144);
      chk("m_dv_clks", dv_cnt, 2400);
      chk("m_vs_low_clks", vs_low, 224);
      chk("m_ls_per_frame", n_ls, 37);
      chk("m_px_max", px_max, 39);
      chk("m_py_max", py_max, 29);
      chk("m_pxy_outside", px_bad, 0);

      // drop Enable mid-line
      found = 0; cnt = 0;
      while (found == 0 && cnt < 5000) begin
         @(posedge clk_sys); #1; cnt++;
         if (m_hc == 8'd30 && m_vc == 8'd10) found = 1;
      end
      chk("m_reach_30_10", found, 1);
      chk("m_pre_dv", int'(m_dv), 1);
      chk("m_pre_px", int'(m_px), 17);
      chk("m_pre_py", int'(m_py), 5);
      m_en = 1'b0;
      @(posedge clk_sys); #1;
      chk("m_idle_hs", int'(m_hs), 1);
      chk("m_idle_vs", int'(m_vs), 1);
      chk("m_idle_dv", int'(m_dv), 0);
      chk("m_idle_px", int'(m_px), 0);
      chk("m_idle_py", int'(m_py), 0);
      chk("m_idle_ls", int'(m_ls), 0);
      chk("m_idle_fs", int'(m_fs), 0);
      chk("m_idle_hc", int'(m_hc), 0);
      chk("m_idle_vc", int'(m_vc), 0);
      chk("m_idle_pe", int'(m_pe), 0);
      repeat (9) @(posedge clk_sys);
      #1;
      chk("m_held_hc", int'(m_hc), 0);
      chk("m_held_hs", int'(m_hs), 1);
      m_en = 1'b1;
      cnt = 1;
      while (!m_fs && cnt < 20) begin @(posedge clk_sys); #1; cnt++; end
      chk("m_fs_after_enable", cnt, 3);
      chk("m_resume_hc", int'(m_hc), 1);
      chk("m_resume_vc", int'(m_vc), 0);
      chk("m_resume_hs", int'(m_hs), 0);

      // asynchronous reset between clock edges
      repeat (700) @(posedge clk_sys);
      #3;
      chk("m_pre_rst_hc_nz", int'(m_hc != 8'd0), 1);
      m_rst = 1'b1;
      #1;
      chk("m_arst_pe", int'(m_pe), 0);
      chk("m_arst_hc", int'(m_hc), 0);
      chk("m_arst_vc", int'(m_vc), 0);
      chk("m_arst_hs", int'(m_hs), 1);
      chk("m_arst_vs", int'(m_vs), 1);
      chk("m_arst_dv", int'(m_dv), 0);
      chk("m_arst_px", int'(m_px), 0);
      chk("m_arst_py", int'(m_py), 0);
      chk("m_arst_ls", int'(m_ls), 0);
      chk("m_arst_fs", int'(m_fs), 0);
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      m_rst = 1'b0;
      cnt = 0;
      while (!m_fs && cnt < 100) begin @(posedge clk_sys); #1; cnt++; end
      chk("m_rst_fs_seen", int'(m_fs), 1);
      per = 0;
      do begin
         per++;
         @(posedge clk_sys); #1;
      end while (!m_fs && per < 5000);
      chk("m_rst_frame_period", per, 4144);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
